decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Decode stage of the non-pipelined LEGv8 core; consumes the 32-bit instruction from Fetch.
//   Extracts fields, classifies format, selects register operands, sign/zero-extends the immediate.
//   Owns the 32x64 register file: two combinational reads, one synchronous write from writeback.
//   Outputs feed Execute/Control. Execute computes the branch offset that returns to Fetch.
// PARAMETERS
//   NUM_REGS  32  architectural registers; X31 = XZR, hardwired to zero
//   WORD      64  datapath width (`WORD)
//   ILEN      32  instruction width (`INSTR_LEN)
// PORTS
//   clk            in   1     core clock; all state changes on posedge
//   reset          in   1     synchronous, active-high; clears the register file
//   instruction    in   32    current instruction from Fetch
//   reg_write      in   1     writeback enable
//   write_data     in   64    writeback value
//   read_data1     out  64    R[Rn]
//   read_data2     out  64    R[Rm] (R-format) or R[Rt] (D/CB-format)
//   imm_ext        out  64    extended immediate (see BEHAVIOUR)
//   dest_reg       out  5     instruction[4:0] (Rd/Rt); write address used at posedge
//   format         out  3     FMT_R/I/D/B/CB/IW/INVALID
//   invalid_instr  out  1     high when format == FMT_INVALID
// BEHAVIOUR
//   - Formats are decoded from opcode MSBs, combinationally:
//       R  = ADD, SUB, AND, ORR (11-bit opcode)
//       I  = ADDI, SUBI (10-bit opcode)
//       D  = LDUR, STUR (11-bit opcode)
//       B  = B, BL (6-bit opcode)
//       CB = CBZ, CBNZ (8-bit opcode)
//       IW = MOVZ (9-bit opcode)
//       Anything else -> FMT_INVALID.
//   - Read addresses:
//       rd1 address = instr[9:5].
//       rd2 address = instr[4:0] for D/CB (Reg2Loc); instr[20:16] otherwise.
//   - Immediates (branch offsets are unshifted word counts; Execute applies <<2):
//       I: zero-extend instr[21:10]
//       D: sign-extend instr[20:12]
//       B: sign-extend instr[25:0]
//       CB: sign-extend instr[23:5]
//       IW: zero-extend instr[20:5] << (16*instr[22:21])
//       INVALID: 0
//   - Reads are combinational, 0 latency. Address 31 always reads 0.
//   - Write:
//       At posedge, if reg_write && !reset && dest_reg != 31: R[dest_reg] <= write_data.
//       A write to 31 is discarded silently.
//   - Same-cycle read and write of one register: the read returns the OLD value.
//     The new value is visible after the edge. No bypass.
//   - Reset:
//       At posedge with reset=1, all registers become 0; this overrides any write that cycle.
//       Outputs are combinational, so after reset read_data* = 0 for any instruction.
//       Reset asserted mid-program behaves identically.
//   - An instruction that is invalid but has reg_write=1 still writes: Control owns gating.
//   - No X propagation: every output is defined for all 2^32 instruction values.
// STRUCTURE
//   - Shared package (constants.vh):
//       FMT_* codes
//       opcode constants OP_ADD .. OP_MOVZ with their widths
//       XZR index 31
//       existing `WORD / `INSTR_LEN
//   - One sub-module, register_file:
//       2R1W, sync reset, XZR handling.
//       decode_stage holds only field extraction, format decode, mux and extension.
// TESTING (bench uses oscillator + `assert, checks 1 ns after posedge)
//   1. Reset 1 cycle; then instruction=0x8B020023 (ADD X3,X1,X2)
//      -> read_data1=0, read_data2=0, format=R, dest_reg=3.
//   2. Writes:
//      - reg_write=1, dest_reg=1, write_data=5; then dest_reg=2, write_data=7.
//      - ADD 0x8B020023 -> read_data1=5, read_data2=7.
//   3. 0xF85F8045 (LDUR X5,[X2,#-8])
//      -> format=D, imm_ext=0xFFFFFFFFFFFFFFF8, read_data1=R[2]=7, rd2 address=5.
//   4. 0xB4FFFFA9 (CBZ X9,#-3) after writing X9=0x1234
//      -> format=CB, read_data2=0x1234, imm_ext=0xFFFFFFFFFFFFFFFD.
//   5. XZR:
//      - reg_write=1, dest=31, write_data=0xDEAD.
//      - Then read via ADD X0,X31,X31 (0x8B1F03E0) -> both reads 0.
//   6. Same-edge read/write:
//      - Write X1=9 while ADD reads X1 -> read_data1=5 before the edge, 9 after.
//      - Then assert reset with reg_write=1 -> X1 reads 0.
//      - 0xFFFFFFFF -> invalid_instr=1, imm_ext=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Shared constants for the LEGv8 decode stage: widths, format
//                codes, opcode values and the zero-register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_AW    = 5;

    localparam logic [REG_AW-1:0] XZR = 5'd31;

    // Instruction format codes
    localparam logic [2:0] FMT_R       = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_D       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_CB      = 3'd4;
    localparam logic [2:0] FMT_IW      = 3'd5;
    localparam logic [2:0] FMT_INVALID = 3'd7;

    // Opcodes, each sized to the opcode field of its format
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

endpackage : decode_stage_pkg
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bus between Fetch/Writeback/Execute and the decode stage.
//                master = surrounding core, slave = decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic [INSTR_LEN-1:0] instruction;
    logic                 reg_write;
    logic [WORD-1:0]      write_data;
    logic [WORD-1:0]      read_data1;
    logic [WORD-1:0]      read_data2;
    logic [WORD-1:0]      imm_ext;
    logic [REG_AW-1:0]    dest_reg;
    logic [2:0]           format;
    logic                 invalid_instr;

    modport master (
        output instruction, reg_write, write_data,
        input  read_data1, read_data2, imm_ext, dest_reg, format, invalid_instr
    );

    modport slave (
        input  instruction, reg_write, write_data,
        output read_data1, read_data2, imm_ext, dest_reg, format, invalid_instr
    );

endinterface : decode_stage_if
`default_nettype wire

// File: rtl/decode_stage_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_register_file
//  Description : 32x64 register file, two combinational reads, one write on
//                posedge. X31 reads as zero and swallows writes. Synchronous
//                reset clears all entries and wins over a same-cycle write.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_register_file
    import decode_stage_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [REG_AW-1:0] raddr1,
    input  wire logic [REG_AW-1:0] raddr2,
    input  wire logic              we,
    input  wire logic [REG_AW-1:0] waddr,
    input  wire logic [WORD-1:0]   wdata,
    output logic      [WORD-1:0]   rdata1,
    output logic      [WORD-1:0]   rdata2
);

    logic [WORD-1:0] regs_q [NUM_REGS];
    logic [WORD-1:0] regs_d [NUM_REGS];

    // Next-state of the array: single write port, XZR writes dropped
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != XZR)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Storage update; reset overrides any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational reads from the stored state only (no write bypass)
    always_comb begin
        rdata1 = (raddr1 == XZR) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == XZR) ? '0 : regs_q[raddr2];
    end

endmodule : decode_stage_register_file
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : LEGv8 decode: field extraction, format classification,
//                Reg2Loc operand select and immediate extension. Owns the
//                register file written by writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    logic [INSTR_LEN-1:0] w_ins;
    logic [2:0]           w_fmt;
    logic [WORD-1:0]      w_imm;
    logic [REG_AW-1:0]    w_raddr2;

    assign w_ins = bus.instruction;

    // Format classification from the opcode MSBs; unmatched encodings are invalid
    always_comb begin
        w_fmt = FMT_INVALID;
        if ((w_ins[31:21] == OP_ADD) || (w_ins[31:21] == OP_SUB) ||
            (w_ins[31:21] == OP_AND) || (w_ins[31:21] == OP_ORR)) begin
            w_fmt = FMT_R;
        end else if ((w_ins[31:22] == OP_ADDI) || (w_ins[31:22] == OP_SUBI)) begin
            w_fmt = FMT_I;
        end else if ((w_ins[31:21] == OP_LDUR) || (w_ins[31:21] == OP_STUR)) begin
            w_fmt = FMT_D;
        end else if ((w_ins[31:26] == OP_B) || (w_ins[31:26] == OP_BL)) begin
            w_fmt = FMT_B;
        end else if ((w_ins[31:24] == OP_CBZ) || (w_ins[31:24] == OP_CBNZ)) begin
            w_fmt = FMT_CB;
        end else if (w_ins[31:23] == OP_MOVZ) begin
            w_fmt = FMT_IW;
        end
    end

    // Immediate extension; branch offsets stay as word counts for Execute
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = {52'd0, w_ins[21:10]};
            FMT_D:   w_imm = {{55{w_ins[20]}}, w_ins[20:12]};
            FMT_B:   w_imm = {{38{w_ins[25]}}, w_ins[25:0]};
            FMT_CB:  w_imm = {{45{w_ins[23]}}, w_ins[23:5]};
            FMT_IW:  w_imm = {48'd0, w_ins[20:5]} << {w_ins[22:21], 4'b0000};
            default: w_imm = '0;
        endcase
    end

    // Reg2Loc: D and CB formats read Rt from the low field as the second operand
    always_comb begin
        w_raddr2 = w_ins[20:16];
        if ((w_fmt == FMT_D) || (w_fmt == FMT_CB)) begin
            w_raddr2 = w_ins[4:0];
        end
    end

    decode_stage_register_file u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (w_ins[9:5]),
        .raddr2 (w_raddr2),
        .we     (bus.reg_write),
        .waddr  (w_ins[4:0]),
        .wdata  (bus.write_data),
        .rdata1 (bus.read_data1),
        .rdata2 (bus.read_data2)
    );

    assign bus.imm_ext       = w_imm;
    assign bus.dest_reg      = w_ins[4:0];
    assign bus.format        = w_fmt;
    assign bus.invalid_instr = (w_fmt == FMT_INVALID);

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                plus randomized instructions against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_D = 3'd2, F_B = 3'd3,
                           F_CB = 3'd4, F_IW = 3'd5, F_INV = 3'd7;

    logic clk = 1'b0;
    logic reset;
    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] model [32];

    // Sign-extend the low 'bits' bits of v
    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        longint t;
        t = longint'(v << (64 - bits));
        return 64'(t >>> (64 - bits));
    endfunction

    // Reference decode built directly from the opcode tables
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] fmt,
                                       output logic [63:0] imm, output logic [4:0] a2);
        logic [10:0] o11;
        o11 = ins[31:21];
        fmt = F_INV;
        imm = 64'd0;
        a2  = ins[20:16];
        if (o11 == 11'h458 || o11 == 11'h658 || o11 == 11'h450 || o11 == 11'h550) begin
            fmt = F_R;
        end else if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344) begin
            fmt = F_I;  imm = {52'd0, ins[21:10]};
        end else if (o11 == 11'h7C2 || o11 == 11'h7C0) begin
            fmt = F_D;  imm = sext({55'd0, ins[20:12]}, 9);  a2 = ins[4:0];
        end else if (ins[31:26] == 6'h05 || ins[31:26] == 6'h25) begin
            fmt = F_B;  imm = sext({38'd0, ins[25:0]}, 26);
        end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5) begin
            fmt = F_CB; imm = sext({45'd0, ins[23:5]}, 19);  a2 = ins[4:0];
        end else if (ins[31:23] == 9'h1A5) begin
            fmt = F_IW; imm = {48'd0, ins[20:5]} * (64'd1 << (16 * int'(ins[22:21])));
        end
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : model[a];
    endfunction

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        logic r, w;
        logic [4:0] d;
        logic [63:0] wd;
        r = reset; w = bus.reg_write; d = bus.instruction[4:0]; wd = bus.write_data;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (w && d != 5'd31) begin
            model[d] = wd;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.reg_write = 1'b0; bus.write_data = 64'd0;
        bus.instruction = 32'h8B020023;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.read_data1 !== 64'd0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", bus.read_data1); end
        checks++; if (bus.read_data2 !== 64'd0) begin errors++; $display("FAIL reset_rd2 got=%h exp=0", bus.read_data2); end
        checks++; if (bus.format !== F_R) begin errors++; $display("FAIL reset_fmt got=%0d exp=%0d", bus.format, F_R); end
        checks++; if (bus.dest_reg !== 5'd3) begin errors++; $display("FAIL reset_dest got=%0d exp=3", bus.dest_reg); end
    endtask

    task automatic test_writes();
        bus.reg_write = 1'b1;
        bus.instruction = 32'h8B020021; bus.write_data = 64'd5; tick();
        bus.instruction = 32'h8B020022; bus.write_data = 64'd7; tick();
        bus.reg_write = 1'b0;
        bus.instruction = 32'h8B020023;
        #1;
        checks++; if (bus.read_data1 !== 64'd5) begin errors++; $display("FAIL add_rd1 got=%h exp=5", bus.read_data1); end
        checks++; if (bus.read_data2 !== 64'd7) begin errors++; $display("FAIL add_rd2 got=%h exp=7", bus.read_data2); end
    endtask

    task automatic test_ldur();
        bus.instruction = 32'hF85F8045;
        #1;
        checks++; if (bus.format !== F_D) begin errors++; $display("FAIL ldur_fmt got=%0d exp=%0d", bus.format, F_D); end
        checks++; if (bus.imm_ext !== 64'hFFFFFFFFFFFFFFF8) begin errors++; $display("FAIL ldur_imm got=%h exp=fffffffffffffff8", bus.imm_ext); end
        checks++; if (bus.read_data1 !== 64'd7) begin errors++; $display("FAIL ldur_rd1 got=%h exp=7", bus.read_data1); end
        checks++; if (bus.read_data2 !== 64'd0) begin errors++; $display("FAIL ldur_rd2_x5 got=%h exp=0", bus.read_data2); end
    endtask

    task automatic test_cbz();
        bus.reg_write = 1'b1; bus.instruction = 32'h8B000009; bus.write_data = 64'h1234; tick();
        bus.reg_write = 1'b0; bus.instruction = 32'hB4FFFFA9;
        #1;
        checks++; if (bus.format !== F_CB) begin errors++; $display("FAIL cbz_fmt got=%0d exp=%0d", bus.format, F_CB); end
        checks++; if (bus.read_data2 !== 64'h1234) begin errors++; $display("FAIL cbz_rd2 got=%h exp=1234", bus.read_data2); end
        checks++; if (bus.imm_ext !== 64'hFFFFFFFFFFFFFFFD) begin errors++; $display("FAIL cbz_imm got=%h exp=fffffffffffffffd", bus.imm_ext); end
    endtask

    task automatic test_xzr();
        bus.reg_write = 1'b1; bus.instruction = 32'h8B00001F; bus.write_data = 64'hDEAD; tick();
        bus.reg_write = 1'b0; bus.instruction = 32'h8B1F03E0;
        #1;
        checks++; if (bus.read_data1 !== 64'd0) begin errors++; $display("FAIL xzr_rd1 got=%h exp=0", bus.read_data1); end
        checks++; if (bus.read_data2 !== 64'd0) begin errors++; $display("FAIL xzr_rd2 got=%h exp=0", bus.read_data2); end
    endtask

    task automatic test_same_edge();
        bus.instruction = 32'h8B020021; bus.reg_write = 1'b1; bus.write_data = 64'd9;
        #1;
        checks++; if (bus.read_data1 !== 64'd5) begin errors++; $display("FAIL rw_before got=%h exp=5", bus.read_data1); end
        tick();
        bus.reg_write = 1'b0;
        #1;
        checks++; if (bus.read_data1 !== 64'd9) begin errors++; $display("FAIL rw_after got=%h exp=9", bus.read_data1); end
        reset = 1'b1; bus.reg_write = 1'b1; bus.write_data = 64'h77; tick();
        reset = 1'b0; bus.reg_write = 1'b0;
        #1;
        checks++; if (bus.read_data1 !== 64'd0) begin errors++; $display("FAIL midreset_rd1 got=%h exp=0", bus.read_data1); end
        checks++; if (bus.read_data2 !== 64'd0) begin errors++; $display("FAIL midreset_rd2 got=%h exp=0", bus.read_data2); end
    endtask

    task automatic test_invalid();
        bus.instruction = 32'hFFFFFFFF;
        #1;
        checks++; if (bus.invalid_instr !== 1'b1) begin errors++; $display("FAIL inv_flag got=%b exp=1", bus.invalid_instr); end
        checks++; if (bus.imm_ext !== 64'd0) begin errors++; $display("FAIL inv_imm got=%h exp=0", bus.imm_ext); end
        checks++; if (bus.format !== F_INV) begin errors++; $display("FAIL inv_fmt got=%0d exp=%0d", bus.format, F_INV); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [2:0]  efmt;
        logic [63:0] eimm;
        logic [4:0]  ea2;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 13))
                0:  ins[31:21] = 11'h458;
                1:  ins[31:21] = 11'h658;
                2:  ins[31:21] = 11'h450;
                3:  ins[31:21] = 11'h550;
                4:  ins[31:22] = 10'h244;
                5:  ins[31:22] = 10'h344;
                6:  ins[31:21] = 11'h7C2;
                7:  ins[31:21] = 11'h7C0;
                8:  ins[31:26] = ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h25;
                9:  ins[31:24] = ($urandom_range(0, 1) == 0) ? 8'hB4 : 8'hB5;
                10: ins[31:23] = 9'h1A5;
                default: ;
            endcase
            bus.instruction = ins;
            bus.reg_write   = $urandom_range(0, 2) != 0;
            bus.write_data  = {$urandom, $urandom};
            reset           = ($urandom_range(0, 49) == 0);
            #1;
            ref_decode(ins, efmt, eimm, ea2);
            checks++; if (bus.format !== efmt) begin errors++; $display("FAIL rnd_fmt ins=%h got=%0d exp=%0d", ins, bus.format, efmt); end
            checks++; if (bus.imm_ext !== eimm) begin errors++; $display("FAIL rnd_imm ins=%h got=%h exp=%h", ins, bus.imm_ext, eimm); end
            checks++; if (bus.invalid_instr !== (efmt == F_INV)) begin errors++; $display("FAIL rnd_inv ins=%h got=%b exp=%b", ins, bus.invalid_instr, efmt == F_INV); end
            checks++; if (bus.dest_reg !== ins[4:0]) begin errors++; $display("FAIL rnd_dest ins=%h got=%0d exp=%0d", ins, bus.dest_reg, ins[4:0]); end
            checks++; if (bus.read_data1 !== ref_read(ins[9:5])) begin errors++; $display("FAIL rnd_rd1 ins=%h got=%h exp=%h", ins, bus.read_data1, ref_read(ins[9:5])); end
            checks++; if (bus.read_data2 !== ref_read(ea2)) begin errors++; $display("FAIL rnd_rd2 ins=%h got=%h exp=%h", ins, bus.read_data2, ref_read(ea2)); end
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        reset = 1'b1;
        bus.instruction = 32'd0;
        bus.reg_write = 1'b0;
        bus.write_data = 64'd0;
        test_reset();
        test_writes();
        test_ldur();
        test_cbz();
        test_xzr();
        test_same_edge();
        test_invalid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
